gap_channel_scheduler: RTL and testbench

Sequences a single shared global-average-pool datapath across all channels of a feature map held in on-chip buffer memory. On `start` it streams each channel's IMG_W×IMG_H pixels from the buffer into the pool unit, captures each per-channel average, and hands it downstream with a valid/ready handshake. Sits between the feature buffer and the classifier/FC stage at the end of the network.

---
 rtl/gap_channel_scheduler_pkg.sv | 21 ++
 rtl/gap_channel_scheduler_if.sv | 27 ++
 rtl/gap_channel_scheduler_addr_gen.sv | 45 ++++
 rtl/gap_channel_scheduler.sv | 112 +++++++++++
 tb/tb_gap_channel_scheduler.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gap_channel_scheduler_pkg.sv
// Shared types and constants for the global-average-pool channel scheduler.
package gap_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RES,
    S_OUTPUT,
    S_DONE
  } state_e;

  localparam int unsigned IMG_W_DEF    = 14;
  localparam int unsigned IMG_H_DEF    = 14;
  localparam int unsigned TOTAL_PIXELS = IMG_W_DEF * IMG_H_DEF;

  // First buffer word of a channel: channels are stored back to back.
  function automatic int unsigned ch_base(input int unsigned ch, input int unsigned total);
    return ch * total;
  endfunction

endpackage

// File: rtl/gap_channel_scheduler_if.sv
// Buffer-read, pool-unit and result handshake signals of the scheduler.
interface gap_channel_scheduler_if #(
  parameter int ADDR_W = 11,
  parameter int CH_W   = 3
) ();
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_data;
  logic              gap_in_valid;
  logic [7:0]        gap_in_data;
  logic              gap_out_valid;
  logic [7:0]        gap_out_data;
  logic              res_valid;
  logic              res_ready;
  logic [CH_W-1:0]   res_ch;
  logic [7:0]        res_data;

  modport master (
    output mem_rd_en, mem_rd_addr, gap_in_valid, gap_in_data, res_valid, res_ch, res_data,
    input  mem_rd_data, gap_out_valid, gap_out_data, res_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, gap_in_valid, gap_in_data, res_valid, res_ch, res_data,
    output mem_rd_data, gap_out_valid, gap_out_data, res_ready
  );
endinterface

// File: rtl/gap_channel_scheduler_addr_gen.sv
// Nested channel/pixel counters producing the feature-buffer read address.
module gap_addr_gen
  import gap_sched_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int TOTAL  = 196,
  parameter int ADDR_W = 11,
  parameter int CH_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic              next_ch_i,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              last_pix_o,
  output logic              last_ch_o
);
  localparam int PIX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic [CH_W-1:0]  ch_q;
  logic [PIX_W-1:0] pix_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q  <= '0;
      pix_q <= '0;
    end else if (clear_i) begin
      ch_q  <= '0;
      pix_q <= '0;
    end else if (next_ch_i) begin
      ch_q  <= ch_q + CH_W'(1);
      pix_q <= '0;
    end else if (advance_i) begin
      pix_q <= pix_q + PIX_W'(1);
    end
  end

  assign mem_rd_addr_o = ADDR_W'(ch_base(32'(ch_q), TOTAL)) + ADDR_W'(pix_q);
  assign ch_o          = ch_q;
  assign last_pix_o    = (pix_q == PIX_W'(TOTAL - 1));
  assign last_ch_o     = (ch_q == CH_W'(NUM_CH - 1));

endmodule

// File: rtl/gap_channel_scheduler.sv
// Streams every channel of a buffered feature map through one shared GAP unit
// and hands the per-channel averages downstream over a valid/ready port.
module gap_channel_scheduler
  import gap_sched_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int NUM_CH  = 8,
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = $clog2(NUM_CH * IMG_W * IMG_H),
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  gap_channel_scheduler_if.master bus
);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             gin_vld_q;
  logic             clr, adv, nxt, last_pix, last_ch;
  logic [CH_W-1:0]  ch;

  gap_addr_gen #(
    .NUM_CH(NUM_CH), .TOTAL(TOTAL), .ADDR_W(ADDR_W), .CH_W(CH_W)
  ) u_addr (
    .clk(clk), .rst_n(rst_n),
    .clear_i(clr), .advance_i(adv), .next_ch_i(nxt),
    .mem_rd_addr_o(bus.mem_rd_addr), .ch_o(ch),
    .last_pix_o(last_pix), .last_ch_o(last_ch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      err_q      <= 1'b0;
      res_data_q <= '0;
      tmo_q      <= '0;
      gin_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      res_data_q <= res_data_d;
      tmo_q      <= tmo_d;
      gin_vld_q  <= bus.mem_rd_en;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    res_data_d = res_data_q;
    tmo_d      = tmo_q;
    clr        = 1'b0;
    adv        = 1'b0;
    nxt        = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        clr     = 1'b1;
        err_d   = 1'b0;
        state_d = S_FETCH;
      end
      S_FETCH: if (last_pix) begin
        tmo_d   = '0;
        state_d = S_WAIT_RES;
      end else begin
        adv = 1'b1;
      end
      S_WAIT_RES: if (bus.gap_out_valid) begin
        res_data_d = bus.gap_out_data;
        state_d    = S_OUTPUT;
      end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        // Still report the channel so downstream sees a complete set.
        err_d      = 1'b1;
        res_data_d = '0;
        state_d    = S_OUTPUT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
      S_OUTPUT: if (bus.res_ready) begin
        if (last_ch) begin
          state_d = S_DONE;
        end else begin
          nxt     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The buffer's own read register aligns its data with the delayed strobe.
  assign bus.mem_rd_en    = (state_q == S_FETCH);
  assign bus.gap_in_valid = gin_vld_q;
  assign bus.gap_in_data  = gin_vld_q ? bus.mem_rd_data : 8'd0;
  assign bus.res_valid    = (state_q == S_OUTPUT);
  assign bus.res_ch       = ch;
  assign bus.res_data     = res_data_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign err              = err_q;

endmodule

// File: tb/tb_gap_channel_scheduler.sv
// Scoreboard bench: a buffer model and a reciprocal-multiply pool stub feed the
// scheduler; a monitor checks results, framing, addresses and hold behaviour.
module tb_gap_channel_scheduler;
  localparam int NUM_CH = 2;
  localparam int TOTAL  = 196;
  localparam int ADDR_W = 9;
  localparam int CH_W   = 1;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       err;
    int         wait_c;
  } exp_t;

  logic clk, rst_n, start, busy, done, err;
  bit   pool_mute;
  logic [7:0] mem [0:NUM_CH*TOTAL-1];

  exp_t exp_q[$];
  exp_t mon_e;
  int n_checks = 0, n_fail = 0, done_cnt = 0;
  int exp_addr, gin_idx, run_len, wait_run;
  bit hold_p, hs_p, hs_last_p;
  logic [CH_W-1:0] hold_ch;
  logic [7:0] hold_data;

  gap_channel_scheduler_if #(.ADDR_W(ADDR_W), .CH_W(CH_W)) bus ();

  gap_channel_scheduler #(
    .IMG_W(14), .IMG_H(14), .NUM_CH(NUM_CH), .TIMEOUT(16), .ADDR_W(ADDR_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Synchronous-read feature buffer.
  always @(posedge clk)
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

  // Pool unit stand-in: average = (sum * 334) >> 16, restart after TOTAL pixels.
  int unsigned p_sum, p_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_sum = 0; p_cnt = 0;
      bus.gap_out_valid <= 1'b0;
      bus.gap_out_data  <= 8'd0;
    end else begin
      bus.gap_out_valid <= 1'b0;
      if (bus.gap_in_valid) begin
        p_sum = p_sum + bus.gap_in_data;
        p_cnt = p_cnt + 1;
        if (p_cnt == TOTAL) begin
          bus.gap_out_valid <= !pool_mute;
          bus.gap_out_data  <= 8'((p_sum * 334) >> 16);
          p_sum = 0; p_cnt = 0;
        end
      end
    end
  end

  // Monitor: scoreboard pop, hold stability, post-handshake behaviour, framing.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_p = 0; hs_p = 0; wait_run = 0; run_len = 0; exp_addr = 0; gin_idx = 0;
    end else begin
      if (done) done_cnt++;
      if (hs_p) begin
        if (hs_last_p) check("done_after_last", done, 1);
        else           check("fetch_after_hs", bus.mem_rd_en, 1);
      end
      if (hold_p) begin
        check("hold_valid", bus.res_valid, 1);
        check("hold_ch", bus.res_ch, hold_ch);
        check("hold_data", bus.res_data, hold_data);
      end
      if (bus.res_valid) check("no_fetch_in_output", bus.mem_rd_en, 0);
      if (bus.mem_rd_en) wait_run = 0;
      else if (busy && !bus.res_valid && !done) wait_run++;
      hs_p      = bus.res_valid && bus.res_ready;
      hold_p    = bus.res_valid && !bus.res_ready;
      hs_last_p = (int'(bus.res_ch) == NUM_CH - 1);
      hold_ch   = bus.res_ch;
      hold_data = bus.res_data;
      if (hs_p) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result: got ch %0d data %0d, expected none", bus.res_ch, bus.res_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("res_ch", bus.res_ch, mon_e.ch);
          check("res_data", bus.res_data, mon_e.data);
          check("res_err", err, mon_e.err);
          check("wait_cycles", wait_run, mon_e.wait_c);
        end
      end
      if (bus.mem_rd_en) begin
        check("rd_addr", bus.mem_rd_addr, exp_addr);
        exp_addr++;
      end
      if (bus.gap_in_valid) begin
        check("gin_data", bus.gap_in_data, mem[gin_idx]);
        gin_idx++; run_len++;
      end else if (run_len != 0) begin
        check("frame_len", run_len, TOTAL);
        run_len = 0;
      end
      if (done) begin exp_addr = 0; gin_idx = 0; end
    end
  end

  task automatic load_mem(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < TOTAL; i++) begin
      mem[i] = a; mem[TOTAL + i] = b;
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic e, input int w);
    exp_t x;
    x.ch = ch; x.data = d; x.err = e; x.wait_c = w;
    exp_q.push_back(x);
  endtask

  task automatic pulse_start(input bit chk);
    @(posedge clk); #1 start = 1'b1;
    if (chk) begin @(negedge clk); check("pre_start_rd_en", bus.mem_rd_en, 0); end
    @(posedge clk); #1 start = 1'b0;
    if (chk) begin
      @(negedge clk);
      check("first_rd_en", bus.mem_rd_en, 1);
      check("first_addr", bus.mem_rd_addr, 0);
      check("first_gin_early", bus.gap_in_valid, 0);
      check("err_cleared", err, 0);
      check("busy_run", busy, 1);
      @(negedge clk);
      check("first_gin_valid", bus.gap_in_valid, 1);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int d0 = done_cnt;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("idle_after_done", busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic wait_addr(input int n);
    bit found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_rd_en && int'(bus.mem_rd_addr) == n) found = 1;
    end
    check("reach_addr", found, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_en", bus.mem_rd_en, 0);
    check("rst_addr", bus.mem_rd_addr, 0);
    check("rst_gin_valid", bus.gap_in_valid, 0);
    check("rst_gin_data", bus.gap_in_data, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_ch", bus.res_ch, 0);
    check("rst_res_data", bus.res_data, 0);
  endtask

  initial begin
    int d0;
    bit seen;
    rst_n = 1'b0; start = 1'b0; bus.res_ready = 1'b1; pool_mute = 1'b0;
    load_mem(8'd100, 8'd255);
    repeat (3) @(posedge clk);
    #1 check_reset_vals();
    rst_n = 1'b1;

    // Basic map: 100 -> 99, 255 -> 254.
    push(0, 8'd99, 1'b0, 2); push(1, 8'd254, 1'b0, 2);
    pulse_start(1);
    wait_done(1000);
    check("err_after_clean", err, 0);

    // Backpressure on ch0.
    bus.res_ready = 1'b0;
    push(0, 8'd99, 1'b0, 2); push(1, 8'd254, 1'b0, 2);
    pulse_start(0);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1;
    end
    check("bp_res_valid_seen", seen, 1);
    repeat (9) @(negedge clk);
    @(posedge clk); #1 bus.res_ready = 1'b1;
    wait_done(1000);

    // Pool never answers: each channel times out and reports 0.
    pool_mute = 1'b1;
    push(0, 8'd0, 1'b1, 16); push(1, 8'd0, 1'b1, 16);
    pulse_start(0);
    wait_done(1000);
    check("err_sticky", err, 1);

    // Next start clears err; pattern 0 / 7 -> 0 / 6.
    pool_mute = 1'b0;
    load_mem(8'd0, 8'd7);
    push(0, 8'd0, 1'b0, 2); push(1, 8'd6, 1'b0, 2);
    pulse_start(1);
    wait_done(1000);

    // start while fetching is ignored.
    load_mem(8'd100, 8'd255);
    push(0, 8'd99, 1'b0, 2); push(1, 8'd254, 1'b0, 2);
    pulse_start(0);
    wait_addr(50);
    pulse_start(0);
    wait_done(1000);

    // Reset at pixel 100 of ch0, then a full clean run.
    pulse_start(0);
    wait_addr(100);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("no_done_after_reset", done_cnt, d0);
    check("idle_after_reset", busy, 0);
    push(0, 8'd99, 1'b0, 2); push(1, 8'd254, 1'b0, 2);
    pulse_start(1);
    wait_done(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
